ipv4_rx_filter: RTL and testbench
=================================

IPV4_RX_FILTER -- requirements
Module: ipv4_rx_filter

Interface
REQ-001 SHALL have parameter LOCAL_IP, default 32'hC0A8_0001, the IPv4 address accepted as destination.
REQ-002 SHALL have parameter CHECK_CSUM, default 1; when set, header checksum errors cause the packet to be dropped.
REQ-003 SHALL have port clock  input  1  rising-edge clock for all logic.
REQ-004 SHALL have port sclr_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port datain  input  8  IPv4 packet byte stream, header first.
REQ-006 SHALL have port ip_en  input  1  high for every byte of one IPv4 packet (EtherType 0x0800 already matched); low between packets.
REQ-007 SHALL have port dataout  output  8  datain delayed one cycle.
REQ-008 SHALL have port data_en  output  1  high while dataout carries the IP payload of an accepted UDP packet; feeds the UDP header stage.
REQ-009 SHALL have port src_ip  output  32  source address of the current packet, valid from the first data_en cycle until the next packet starts.
REQ-010 SHALL have port udp_len  output  16  IP total length minus header length, valid with src_ip.
REQ-011 SHALL have port hdr_err  output  1  one-cycle pulse when a packet is rejected.

Function
REQ-012 SHALL index bytes k=0,1,... from the first ip_en-high cycle; each ip_en-high cycle advances k by one.
REQ-013 SHALL run a state machine: IDLE -> HEADER on ip_en; HEADER -> PAYLOAD at k=H if accepted, else -> DROP; PAYLOAD -> DROP when the payload count reaches udp_len; any state -> IDLE when ip_en is low.
REQ-014 SHALL take H = 4*IHL from byte 0 bits [3:0]; version (bits [7:4]) SHALL equal 4.
REQ-015 SHALL accept a packet only if version=4, 5<=IHL<=15, total length (bytes 2-3) >= H, flags MF=0 and fragment offset=0 (bytes 6-7), protocol (byte 9)=17, destination (bytes 16-19)=LOCAL_IP, and (CHECK_CSUM=0 or checksum valid).
REQ-016 SHALL compute the checksum as the 16-bit ones'-complement sum, with end-around carry, of all H/2 big-endian header words (options included); it is valid when the sum equals 16'hFFFF.
REQ-017 SHALL skip option bytes (k=20..H-1) except for the checksum.
REQ-018 SHALL make the accept decision in the cycle datain carries byte H, so data_en rises with that byte on dataout; latency datain->dataout is exactly 1 cycle.
REQ-019 SHALL hold data_en high for exactly udp_len bytes, then drop it even if ip_en stays high (Ethernet padding); udp_len=0 produces no data_en cycle.
REQ-020 SHALL pulse hdr_err once at the decision cycle (+1 output register) on rejection, and also when ip_en falls before byte H (truncated header).
REQ-021 SHALL deassert data_en one cycle after ip_en falls (aligned with dataout), even when udp_len has not been reached.
REQ-022 SHALL treat ip_en low for one cycle between back-to-back packets as a packet boundary, fully re-arming on the next high cycle.
REQ-023 SHALL update src_ip and udp_len only on acceptance; rejected packets leave previous values unchanged.

Reset
REQ-024 SHALL, while sclr_n is low, force state IDLE, counters and checksum to 0, dataout=8'h00, data_en=0, hdr_err=0, src_ip=0, udp_len=0.
REQ-025 SHALL, after sclr_n is released mid-packet, ignore the remainder of that packet until ip_en is low for at least one cycle.

Structure
REQ-026 SHALL place state encodings, IPv4 field offsets (VER_IHL=0, TLEN=2, FRAG=6, PROTO=9, SRC=12, DST=16), PROTO_UDP=17 and MIN_IHL=5 in a shared package ip_pkg.
REQ-027 SHALL implement the checksum accumulator as sub-module ip_csum_acc (clear, byte in, byte-parity select, 16-bit sum out).

Verification
REQ-028 SHALL verify: valid 20-byte header, dst=192.168.0.1, proto 17, total length 28 + 8 payload bytes -> data_en high exactly 8 cycles starting 21 cycles after ip_en rises; udp_len=8; hdr_err=0.
REQ-029 SHALL verify: same packet with checksum byte 10 flipped -> no data_en, one hdr_err pulse; with CHECK_CSUM=0 -> accepted.
REQ-030 SHALL verify: IHL=6 (4 option bytes), total length 32 -> data_en starts at payload byte 24 for 8 cycles.
REQ-031 SHALL verify: proto 6 (TCP) or dst 192.168.0.2 -> no data_en, hdr_err pulse; src_ip and udp_len keep prior values.
REQ-032 SHALL verify: total length 28 followed by 18 padding bytes -> data_en exactly 8 cycles; ip_en dropped at byte 12 -> hdr_err pulse, return to IDLE.
REQ-033 SHALL verify: sclr_n asserted during payload -> outputs 0 immediately; next packet after a one-cycle ip_en gap is accepted normally.

Source files
------------

// File: rtl/ip_pkg.sv
// Shared IPv4 receive definitions: FSM state encoding, header field byte
// offsets, protocol/IHL constants, the captured-header record and a helper
// that turns IHL into the header length in bytes.
package ip_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_DROP    = 2'd3
  } ip_state_e;

  localparam logic [5:0] OFF_VER_IHL = 6'd0;
  localparam logic [5:0] OFF_TLEN    = 6'd2;
  localparam logic [5:0] OFF_FRAG    = 6'd6;
  localparam logic [5:0] OFF_PROTO   = 6'd9;
  localparam logic [5:0] OFF_SRC     = 6'd12;
  localparam logic [5:0] OFF_DST     = 6'd16;

  localparam logic [7:0] PROTO_UDP = 8'd17;
  localparam logic [3:0] MIN_IHL   = 4'd5;
  localparam logic [3:0] IP_VER4   = 4'd4;

  // frag keeps MF + 13-bit offset only; reserved/DF bits are don't-care.
  typedef struct packed {
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [15:0] tlen;
    logic [13:0] frag;
    logic [7:0]  proto;
    logic [31:0] src;
    logic [31:0] dst;
  } ip_hdr_t;

  // Illegal IHL (<5) still needs a decision point; use the minimum header.
  function automatic logic [5:0] hdr_bytes(input logic [3:0] ihl);
    return (ihl < MIN_IHL) ? 6'd20 : {ihl, 2'b00};
  endfunction
endpackage

// File: rtl/ip_csum_acc.sv
// Byte-serial 16-bit ones'-complement accumulator for the IPv4 header
// checksum.
//   clock, sclr_n : clock / async active-low reset
//   i_clr         : restart the sum (may coincide with i_en: sum = 0 + byte)
//   i_en          : accumulate i_byte this cycle
//   i_hi          : i_byte is the high (even-offset) byte of its word
//   o_sum         : running sum, end-around carry already folded
module ip_csum_acc (
  input  logic        clock,
  input  logic        sclr_n,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic        i_hi,
  input  logic [7:0]  i_byte,
  output logic [15:0] o_sum
);
  logic [15:0] r_sum;
  logic [15:0] w_base;
  logic [15:0] w_word;
  logic [16:0] w_add;

  assign w_base = i_clr ? 16'h0000 : r_sum;
  assign w_word = i_hi ? {i_byte, 8'h00} : {8'h00, i_byte};
  assign w_add  = {1'b0, w_base} + {1'b0, w_word};

  // One fold suffices: two 16-bit operands never carry twice.
  always_ff @(posedge clock or negedge sclr_n) begin
    if (!sclr_n)    r_sum <= 16'h0000;
    else if (i_en)  r_sum <= w_add[15:0] + {15'd0, w_add[16]};
    else if (i_clr) r_sum <= 16'h0000;
  end

  assign o_sum = r_sum;
endmodule

// File: rtl/ipv4_rx_filter.sv
// IPv4 receive filter: parses the header of a byte-serial packet, accepts
// unfragmented UDP to LOCAL_IP with a good checksum, and flags the payload
// bytes on a one-cycle delayed copy of the stream.
//   clock, sclr_n : clock / async active-low reset
//   datain, ip_en : packet bytes, ip_en high for the whole packet
//   dataout       : datain delayed one cycle
//   data_en       : dataout is IP payload of an accepted packet
//   src_ip        : source address of the last accepted packet
//   udp_len       : total length minus header length of that packet
//   hdr_err       : one-cycle pulse on rejection or truncated header
module ipv4_rx_filter
  import ip_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0001,
  parameter bit          CHECK_CSUM = 1'b1
) (
  input  logic        clock,
  input  logic        sclr_n,
  input  logic [7:0]  datain,
  input  logic        ip_en,
  output logic [7:0]  dataout,
  output logic        data_en,
  output logic [31:0] src_ip,
  output logic [15:0] udp_len,
  output logic        hdr_err
);
  ip_state_e   r_state, w_state_nxt;
  ip_hdr_t     r_hdr;
  logic [5:0]  r_k, w_k, w_hlen;
  logic [15:0] r_pcnt, r_udp_len, w_plen, w_sum;
  logic [31:0] r_src_ip;
  logic [7:0]  r_dout;
  logic        r_armed, r_de, r_err;
  logic        w_start, w_hdr_byte, w_decide, w_accept, w_de_nxt, w_err_nxt;

  // r_armed stays low after reset until ip_en is seen low, so a packet cut
  // by reset is ignored to its end.
  assign w_start    = (r_state == ST_IDLE) && ip_en && r_armed;
  assign w_k        = (r_state == ST_IDLE) ? 6'd0 : r_k;
  assign w_hlen     = hdr_bytes(r_hdr.ihl);
  assign w_hdr_byte = w_start || ((r_state == ST_HEADER) && ip_en && (r_k < w_hlen));
  assign w_decide   = (r_state == ST_HEADER) && ip_en && (r_k == w_hlen);
  assign w_plen     = r_hdr.tlen - {10'd0, w_hlen};

  assign w_accept = (r_hdr.ver == IP_VER4) && (r_hdr.ihl >= MIN_IHL)
                 && (r_hdr.tlen >= {10'd0, w_hlen}) && (r_hdr.frag == 14'd0)
                 && (r_hdr.proto == PROTO_UDP) && (r_hdr.dst == LOCAL_IP)
                 && (!CHECK_CSUM || (w_sum == 16'hFFFF));

  ip_csum_acc u_csum (
    .clock  (clock),
    .sclr_n (sclr_n),
    .i_clr  (r_state == ST_IDLE),
    .i_en   (w_hdr_byte),
    .i_hi   (~w_k[0]),
    .i_byte (datain),
    .o_sum  (w_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_de_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    if (!ip_en) begin
      w_state_nxt = ST_IDLE;
      w_err_nxt   = (r_state == ST_HEADER);
    end else begin
      case (r_state)
        ST_IDLE:   if (r_armed) w_state_nxt = ST_HEADER;
        ST_HEADER: if (w_decide) begin
          if (w_accept && (w_plen != 16'd0)) begin
            w_state_nxt = ST_PAYLOAD;
            w_de_nxt    = 1'b1;
          end else begin
            w_state_nxt = ST_DROP;
            w_err_nxt   = !w_accept;
          end
        end
        ST_PAYLOAD: if (r_pcnt == r_udp_len) w_state_nxt = ST_DROP;
                    else                     w_de_nxt    = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge sclr_n) begin
    if (!sclr_n) begin
      r_state   <= ST_IDLE;
      r_armed   <= 1'b0;
      r_k       <= 6'd0;
      r_pcnt    <= 16'd0;
      r_hdr     <= '0;
      r_dout    <= 8'h00;
      r_de      <= 1'b0;
      r_err     <= 1'b0;
      r_src_ip  <= 32'd0;
      r_udp_len <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_dout  <= datain;
      r_de    <= w_de_nxt;
      r_err   <= w_err_nxt;
      if (!ip_en) r_armed <= 1'b1;

      if (w_state_nxt == ST_IDLE) r_k <= 6'd0;
      else if (w_start)           r_k <= 6'd1;
      else if (w_hdr_byte)        r_k <= r_k + 6'd1;

      // Payload byte 0 is the decision byte itself.
      if (w_state_nxt == ST_IDLE)                 r_pcnt <= 16'd0;
      else if (w_decide)                          r_pcnt <= 16'd1;
      else if ((r_state == ST_PAYLOAD) && w_de_nxt) r_pcnt <= r_pcnt + 16'd1;

      if (w_hdr_byte) begin
        if (w_k == OFF_VER_IHL)       {r_hdr.ver, r_hdr.ihl} <= datain;
        if (w_k == OFF_TLEN)          r_hdr.tlen[15:8]       <= datain;
        if (w_k == OFF_TLEN + 6'd1)   r_hdr.tlen[7:0]        <= datain;
        if (w_k == OFF_FRAG)          r_hdr.frag[13:8]       <= datain[5:0];
        if (w_k == OFF_FRAG + 6'd1)   r_hdr.frag[7:0]        <= datain;
        if (w_k == OFF_PROTO)         r_hdr.proto            <= datain;
        if ((w_k >= OFF_SRC) && (w_k < OFF_SRC + 6'd4))
          r_hdr.src <= {r_hdr.src[23:0], datain};
        if ((w_k >= OFF_DST) && (w_k < OFF_DST + 6'd4))
          r_hdr.dst <= {r_hdr.dst[23:0], datain};
      end

      if (w_decide && w_accept) begin
        r_src_ip  <= r_hdr.src;
        r_udp_len <= w_plen;
      end
    end
  end

  assign dataout = r_dout;
  assign data_en = r_de;
  assign hdr_err = r_err;
  assign src_ip  = r_src_ip;
  assign udp_len = r_udp_len;
endmodule

// File: tb/tb_ipv4_rx_filter.sv
module tb_ipv4_rx_filter;
  localparam logic [31:0] LOC = 32'hC0A8_0001;

  typedef struct {
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [15:0] tlen;
    logic [15:0] frag;
    logic [7:0]  proto;
    logic [31:0] dst;
    bit          bad_cs;
    int          n_en;
    bit          acc;
    logic [15:0] ulen;
  } vec_t;

  typedef struct {
    logic [7:0] dout;
    logic       de;
    logic       err;
  } exp_t;

  logic        clock, sclr_n, ip_en;
  logic [7:0]  datain;
  logic [7:0]  dataout, n_dout;
  logic        data_en, hdr_err, n_de, n_err;
  logic [31:0] src_ip, n_src;
  logic [15:0] udp_len, n_ulen;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   nocs_cnt = 0;
  exp_t sbq[$];
  exp_t mon_e;
  logic [7:0]  pkt [64];
  logic [31:0] m_src;
  logic [15:0] m_ulen;
  vec_t vecs [15];

  ipv4_rx_filter #(.LOCAL_IP(LOC), .CHECK_CSUM(1'b1)) u_dut (
    .clock(clock), .sclr_n(sclr_n), .datain(datain), .ip_en(ip_en),
    .dataout(dataout), .data_en(data_en), .src_ip(src_ip),
    .udp_len(udp_len), .hdr_err(hdr_err));

  ipv4_rx_filter #(.LOCAL_IP(LOC), .CHECK_CSUM(1'b0)) u_nocs (
    .clock(clock), .sclr_n(sclr_n), .datain(datain), .ip_en(ip_en),
    .dataout(n_dout), .data_en(n_de), .src_ip(n_src),
    .udp_len(n_ulen), .hdr_err(n_err));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    #2;
    if (n_de) nocs_cnt++;
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      chk("dataout", {24'd0, dataout}, {24'd0, mon_e.dout});
      chk("data_en", {31'd0, data_en}, {31'd0, mon_e.de});
      chk("hdr_err", {31'd0, hdr_err}, {31'd0, mon_e.err});
    end
  end

  task automatic step(input logic [7:0] d, input logic en, input exp_t e);
    @(negedge clock);
    datain = d;
    ip_en  = en;
    sbq.push_back(e);
  endtask

  task automatic drain();
    for (int t = 0; t < 10 && sbq.size() != 0; t++) @(posedge clock);
    @(posedge clock);
    #3;
    n_tests++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  function automatic int hlen_of(input logic [3:0] ihl);
    return (ihl < 4'd5) ? 20 : int'(ihl) * 4;
  endfunction

  task automatic build(input vec_t v, input logic [31:0] src);
    int h;
    logic [16:0] s;
    logic [15:0] cs;
    h = hlen_of(v.ihl);
    for (int i = 0; i < 64; i++) pkt[i] = 8'hA0 + 8'(i);
    for (int i = 20; i < h; i++) pkt[i] = 8'h01;
    pkt[0] = {v.ver, v.ihl}; pkt[1] = 8'h00;
    pkt[2] = v.tlen[15:8];   pkt[3] = v.tlen[7:0];
    pkt[4] = 8'h12;          pkt[5] = 8'h34;
    pkt[6] = v.frag[15:8];   pkt[7] = v.frag[7:0];
    pkt[8] = 8'h40;          pkt[9] = v.proto;
    pkt[10] = 8'h00;         pkt[11] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      pkt[12+i] = src[31-8*i -: 8];
      pkt[16+i] = v.dst[31-8*i -: 8];
    end
    s = 17'd0;
    for (int i = 0; i < h; i += 2) begin
      s = {1'b0, s[15:0]} + {1'b0, pkt[i], pkt[i+1]};
      s = {1'b0, s[15:0] + {15'd0, s[16]}};
    end
    cs = ~s[15:0];
    pkt[10] = cs[15:8];
    pkt[11] = cs[7:0];
    if (v.bad_cs) pkt[10] = pkt[10] ^ 8'h01;
  endtask

  task automatic run_pkt(input vec_t v, input logic [31:0] src);
    int   h;
    bit   trunc;
    exp_t e;
    build(v, src);
    h = hlen_of(v.ihl);
    trunc = (v.n_en <= h);
    for (int i = 0; i < v.n_en; i++) begin
      e.dout = pkt[i];
      e.de   = v.acc && (i >= h) && (i < h + int'(v.ulen));
      e.err  = !v.acc && !trunc && (i == h);
      step(pkt[i], 1'b1, e);
    end
    e.dout = 8'h00; e.de = 1'b0; e.err = trunc;
    step(8'h00, 1'b0, e);
    if (v.acc) begin m_src = src; m_ulen = v.ulen; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   base;
    //           ver  ihl  tlen    frag      proto dst            bad n   acc ulen
    vecs[0]  = '{4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, LOC,          0, 28, 1, 16'd8};
    vecs[1]  = '{4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, LOC,          1, 28, 0, 16'd0};
    vecs[2]  = '{4'd4, 4'd6, 16'd32, 16'h0000, 8'd17, LOC,          0, 32, 1, 16'd8};
    vecs[3]  = '{4'd4, 4'd5, 16'd28, 16'h0000, 8'd6,  LOC,          0, 28, 0, 16'd0};
    vecs[4]  = '{4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, 32'hC0A80002, 0, 28, 0, 16'd0};
    vecs[5]  = '{4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, LOC,          0, 46, 1, 16'd8};
    vecs[6]  = '{4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, LOC,          0, 12, 0, 16'd0};
    vecs[7]  = '{4'd4, 4'd5, 16'd28, 16'h2000, 8'd17, LOC,          0, 28, 0, 16'd0};
    vecs[8]  = '{4'd4, 4'd5, 16'd28, 16'h4000, 8'd17, LOC,          0, 28, 1, 16'd8};
    vecs[9]  = '{4'd4, 4'd5, 16'd28, 16'h0001, 8'd17, LOC,          0, 28, 0, 16'd0};
    vecs[10] = '{4'd4, 4'd5, 16'd20, 16'h0000, 8'd17, LOC,          0, 24, 1, 16'd0};
    vecs[11] = '{4'd6, 4'd5, 16'd28, 16'h0000, 8'd17, LOC,          0, 28, 0, 16'd0};
    vecs[12] = '{4'd4, 4'd5, 16'd19, 16'h0000, 8'd17, LOC,          0, 24, 0, 16'd0};
    vecs[13] = '{4'd4, 4'd5, 16'd28, 16'h0000, 8'd17, LOC,          0, 24, 1, 16'd8};
    vecs[14] = '{4'd4, 4'd4, 16'd28, 16'h0000, 8'd17, LOC,          0, 28, 0, 16'd0};

    sclr_n = 1'b0; ip_en = 1'b0; datain = 8'h00;
    m_src = 32'd0; m_ulen = 16'd0;
    #12;
    chk("rst dataout", {24'd0, dataout}, 32'd0);
    chk("rst data_en", {31'd0, data_en}, 32'd0);
    chk("rst hdr_err", {31'd0, hdr_err}, 32'd0);
    chk("rst src_ip",  src_ip, 32'd0);
    chk("rst udp_len", {16'd0, udp_len}, 32'd0);
    @(negedge clock);
    sclr_n = 1'b1;
    e = '{8'h00, 1'b0, 1'b0};
    step(8'h00, 1'b0, e);

    for (int c = 0; c < 15; c++) begin
      base = nocs_cnt;
      run_pkt(vecs[c], 32'h0A00_0100 + 32'(c));
      drain();
      chk($sformatf("src_ip v%0d", c), src_ip, m_src);
      chk($sformatf("udp_len v%0d", c), {16'd0, udp_len}, {16'd0, m_ulen});
      if (c == 1) begin
        chk("nocs data_en cycles", 32'(nocs_cnt - base), 32'd8);
        chk("nocs src_ip", n_src, 32'h0A00_0101);
      end
    end

    // Reset in the middle of an accepted payload.
    build(vecs[0], 32'h0A00_0200);
    for (int i = 0; i < 23; i++) begin
      e.dout = pkt[i]; e.de = (i >= 20); e.err = 1'b0;
      step(pkt[i], 1'b1, e);
    end
    drain();
    chk("pre-reset data_en", {31'd0, data_en}, 32'd1);
    sclr_n = 1'b0;
    #1;
    chk("midrst dataout", {24'd0, dataout}, 32'd0);
    chk("midrst data_en", {31'd0, data_en}, 32'd0);
    chk("midrst src_ip",  src_ip, 32'd0);
    chk("midrst udp_len", {16'd0, udp_len}, 32'd0);
    for (int i = 23; i < 25; i++) begin
      @(negedge clock);
      datain = pkt[i]; ip_en = 1'b1;
    end
    for (int i = 25; i < 34; i++) begin
      e = '{pkt[i], 1'b0, 1'b0};
      step(pkt[i], 1'b1, e);
      sclr_n = 1'b1;
    end
    e = '{8'h00, 1'b0, 1'b0};
    step(8'h00, 1'b0, e);
    m_src = 32'd0; m_ulen = 16'd0;
    drain();
    chk("post-rst src_ip",  src_ip, m_src);
    chk("post-rst udp_len", {16'd0, udp_len}, {16'd0, m_ulen});
    run_pkt(vecs[0], 32'h0A00_0300);
    drain();
    chk("rearm src_ip",  src_ip, m_src);
    chk("rearm udp_len", {16'd0, udp_len}, {16'd0, m_ulen});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
